// File: rtl/cook_timer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cook_timer_pkg                                               |
// | Description : Shared state encoding and BCD constants for the cook timer.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package cook_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SET   = 2'd1,
    COOK  = 2'd2,
    PAUSE = 2'd3
  } state_t;

  localparam logic [3:0] ZERO            = 4'd0;
  localparam logic [3:0] NINE            = 4'd9;
  localparam logic [3:0] SEC_TENS_RELOAD = 4'd5;

  function automatic logic is_bcd(input logic [3:0] d);
    return d <= NINE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_cell.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bcd_digit_cell                                               |
// | Description : One BCD timer digit with shift-in load, borrow-chained       |
// |               decrement and zero detect.                                   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module bcd_digit_cell
  import cook_timer_pkg::*;
#(
  parameter logic [3:0] RELOAD = NINE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_shift,
  input  logic [3:0] i_shift_in,
  input  logic       i_dec,
  input  logic       i_borrow_in,
  output logic [3:0] o_digit,
  output logic       o_borrow_out,
  output logic       o_zero
);

  logic [3:0] r_digit;

  // A digit only moves on a decrement when every lower digit is zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_digit <= ZERO;
    end else if (i_clr) begin
      r_digit <= ZERO;
    end else if (i_shift) begin
      r_digit <= i_shift_in;
    end else if (i_dec && i_borrow_in) begin
      r_digit <= (r_digit == ZERO) ? RELOAD : r_digit - 4'd1;
    end
  end

  assign o_digit      = r_digit;
  assign o_zero       = (r_digit == ZERO);
  assign o_borrow_out = i_borrow_in && (r_digit == ZERO);

endmodule
`default_nettype wire

// File: rtl/cook_timer_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cook_timer_ctrl                                              |
// | Description : Microwave cook timer: keypad BCD entry, second countdown,    |
// |               door interlock and duty-cycled magnetron power control.      |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module cook_timer_ctrl
  import cook_timer_pkg::*;
#(
  parameter int MIN_DIGITS = 2,
  parameter int TICK_DIV   = 100,
  parameter int POWER_MAX  = 10
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    key_valid,
  input  logic [3:0]              key_digit,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    clear,
  input  logic                    door_closed,
  input  logic [3:0]              power_level,
  output logic [3:0]              sec_ones,
  output logic [3:0]              sec_tens,
  output logic [4*MIN_DIGITS-1:0] mins,
  output logic                    mag_on,
  output logic [1:0]              state,
  output logic                    done
);

  localparam int c_num_dig = MIN_DIGITS + 2;
  localparam int c_pre_w   = $clog2(TICK_DIV);
  localparam int c_lvl_w   = (POWER_MAX > 15) ? $clog2(POWER_MAX + 1) : 4;

  localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(TICK_DIV - 1);
  localparam logic [c_lvl_w-1:0] c_lvl_max  = c_lvl_w'(POWER_MAX);
  localparam logic [c_lvl_w-1:0] c_win_last = c_lvl_w'(POWER_MAX - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_pre_w-1:0]   r_presc;
  logic [c_lvl_w-1:0]   r_win;
  logic [c_lvl_w-1:0]   r_level;
  logic                 r_done;

  logic                 w_shift;
  logic                 w_clr;
  logic                 w_dec;
  logic                 w_start_ok;
  logic                 w_done;
  logic                 w_key_ok;
  logic                 w_shift_nz;
  logic                 w_last;
  logic                 w_tick;
  logic                 w_time_zero;

  logic [3:0]           w_digit     [c_num_dig];
  logic [3:0]           w_shift_src [c_num_dig];
  logic [c_num_dig-1:0] w_zero;
  logic [c_num_dig:0]   w_borrow;

  // Digit 0 is sec_ones, digit 1 is sec_tens, digits 2.. are minutes.
  assign w_borrow[0] = 1'b1;

  for (genvar gi = 0; gi < c_num_dig; gi++) begin : g_digit
    if (gi == 0) begin : g_lsd
      assign w_shift_src[gi] = key_digit;
    end else begin : g_upper
      assign w_shift_src[gi] = w_digit[gi-1];
    end

    bcd_digit_cell #(
      .RELOAD ((gi == 1) ? SEC_TENS_RELOAD : NINE)
    ) u_cell (
      .clk          (clock),
      .rst          (reset),
      .i_clr        (w_clr),
      .i_shift      (w_shift),
      .i_shift_in   (w_shift_src[gi]),
      .i_dec        (w_dec),
      .i_borrow_in  (w_borrow[gi]),
      .o_digit      (w_digit[gi]),
      .o_borrow_out (w_borrow[gi+1]),
      .o_zero       (w_zero[gi])
    );
  end

  for (genvar gm = 0; gm < MIN_DIGITS; gm++) begin : g_mins
    assign mins[4*gm +: 4] = w_digit[gm+2];
  end

  assign w_time_zero = w_borrow[c_num_dig];
  assign w_key_ok    = key_valid && is_bcd(key_digit);
  assign w_shift_nz  = (key_digit != ZERO) || (|(~w_zero[c_num_dig-2:0]));
  assign w_last      = (w_digit[0] == 4'd1) && (&w_zero[c_num_dig-1:1]);
  assign w_tick      = (r_state == COOK) && (r_presc == c_pre_last);

  always_comb begin
    w_state_nxt = r_state;
    w_shift     = 1'b0;
    w_clr       = 1'b0;
    w_dec       = 1'b0;
    w_start_ok  = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE, SET: begin
        if (clear || stop) begin
          w_clr       = 1'b1;
          w_state_nxt = IDLE;
        end else if (start && door_closed && (r_state == SET)) begin
          w_start_ok  = 1'b1;
          w_state_nxt = COOK;
        end else if (w_key_ok) begin
          // Shifting can push the only non-zero digit off the top.
          w_shift     = 1'b1;
          w_state_nxt = w_shift_nz ? SET : IDLE;
        end
      end
      COOK: begin
        if (clear) begin
          w_clr       = 1'b1;
          w_state_nxt = IDLE;
        end else if (stop || !door_closed) begin
          w_state_nxt = PAUSE;
        end else if (w_tick && !w_time_zero) begin
          w_dec = 1'b1;
          if (w_last) begin
            w_state_nxt = IDLE;
            w_done      = 1'b1;
          end
        end
      end
      PAUSE: begin
        if (clear || stop) begin
          w_clr       = 1'b1;
          w_state_nxt = IDLE;
        end else if (start && door_closed) begin
          w_start_ok  = 1'b1;
          w_state_nxt = COOK;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_presc <= '0;
      r_win   <= '0;
      r_level <= c_lvl_max;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done;
      if (w_start_ok) begin
        r_presc <= '0;
        r_win   <= '0;
        if (w_state_nxt == COOK && r_state == SET) begin
          r_level <= ((power_level == 4'd0) || (32'(power_level) > POWER_MAX))
                     ? c_lvl_max : c_lvl_w'(power_level);
        end
      end else if (r_state == COOK) begin
        r_presc <= w_tick ? '0 : r_presc + 1'b1;
        if (w_tick) begin
          r_win <= (r_win == c_win_last) ? '0 : r_win + 1'b1;
        end
      end
    end
  end

  assign mag_on   = (r_state == COOK) && door_closed && (r_win < r_level);
  assign done     = r_done;
  assign state    = r_state;
  assign sec_ones = w_digit[0];
  assign sec_tens = w_digit[1];

endmodule
`default_nettype wire

// File: tb/tb_cook_timer_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_cook_timer_ctrl                                           |
// | Description : Scoreboard bench for cook_timer_ctrl (TICK_DIV=4).           |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_cook_timer_ctrl;
  import cook_timer_pkg::*;

  localparam int TICK = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clear = 1'b0;
  logic       door_closed = 1'b1;
  logic [3:0] power_level = 4'd10;

  logic [3:0] sec_ones, sec_tens, sec_ones1, sec_tens1;
  logic [7:0] mins;
  logic [3:0] mins1;
  logic       mag_on, done, mag_on1, done1;
  logic [1:0] state, state1;

  cook_timer_ctrl #(.MIN_DIGITS(2), .TICK_DIV(TICK), .POWER_MAX(10)) dut (
    .clock(clock), .reset(reset), .key_valid(key_valid), .key_digit(key_digit),
    .start(start), .stop(stop), .clear(clear), .door_closed(door_closed),
    .power_level(power_level), .sec_ones(sec_ones), .sec_tens(sec_tens),
    .mins(mins), .mag_on(mag_on), .state(state), .done(done)
  );

  cook_timer_ctrl #(.MIN_DIGITS(1), .TICK_DIV(TICK), .POWER_MAX(10)) dut1 (
    .clock(clock), .reset(reset), .key_valid(key_valid), .key_digit(key_digit),
    .start(start), .stop(stop), .clear(clear), .door_closed(door_closed),
    .power_level(power_level), .sec_ones(sec_ones1), .sec_tens(sec_tens1),
    .mins(mins1), .mag_on(mag_on1), .state(state1), .done(done1)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      name;
    logic [19:0] v;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  logic [19:0] obs;
  logic [19:0] obs1;
  assign obs  = {state, mins, sec_tens, sec_ones, mag_on, done};
  assign obs1 = {4'h0, state1, mins1, sec_tens1, sec_ones1, mag_on1, done1};

  function automatic logic [19:0] mk(logic [1:0] s, logic [7:0] mn, logic [3:0] t,
                                     logic [3:0] o, logic m, logic d);
    return {s, mn, t, o, m, d};
  endfunction

  task automatic step(int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push(string nm, logic [19:0] v);
    q.push_back('{name: nm, v: v});
  endtask

  task automatic do_reset();
    reset = 1'b1; key_valid = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
    door_closed = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic press(logic [3:0] d);
    key_valid = 1'b1; key_digit = d;
    step();
    key_valid = 1'b0;
  endtask

  task automatic go(logic [3:0] pl);
    power_level = pl; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic clr();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1; start = 1'b1; key_valid = 1'b1; key_digit = 4'd5;
    push("reset_state", mk(IDLE, 8'h00, 4'd0, 4'd0, 1'b0, 1'b0));
    step();
    e = q.pop_front(); n_chk++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    reset = 1'b0; start = 1'b0; key_valid = 1'b0;
  endtask

  task automatic test_entry();
    exp_t e;
    press(4'd1); press(4'd3); press(4'd0);
    push("entry_130", mk(SET, 8'h01, 4'd3, 4'd0, 1'b0, 1'b0));
    e = q.pop_front(); n_chk++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    door_closed = 1'b0;
    go(4'd10);
    push("start_door_open", mk(SET, 8'h01, 4'd3, 4'd0, 1'b0, 1'b0));
    e = q.pop_front(); n_chk++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    door_closed = 1'b1;
  endtask

  task automatic test_countdown();
    exp_t e;
    int   waits[6] = '{0, 3, 1, 4, 3, 1};
    logic [19:0] exps[6];
    exps[0] = mk(COOK, 8'h00, 4'd0, 4'd3, 1'b1, 1'b0);
    exps[1] = mk(COOK, 8'h00, 4'd0, 4'd3, 1'b1, 1'b0);
    exps[2] = mk(COOK, 8'h00, 4'd0, 4'd2, 1'b1, 1'b0);
    exps[3] = mk(COOK, 8'h00, 4'd0, 4'd1, 1'b1, 1'b0);
    exps[4] = mk(COOK, 8'h00, 4'd0, 4'd1, 1'b1, 1'b0);
    exps[5] = mk(IDLE, 8'h00, 4'd0, 4'd0, 1'b0, 1'b1);
    do_reset();
    press(4'd3);
    go(4'd10);
    for (int i = 0; i < 6; i++) begin
      if (waits[i] > 0) step(waits[i]);
      push($sformatf("countdown_%0d", i), exps[i]);
      e = q.pop_front(); n_chk++;
      if (obs !== e.v) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    end
    step();
    push("done_one_cycle", mk(IDLE, 8'h00, 4'd0, 4'd0, 1'b0, 1'b0));
    e = q.pop_front(); n_chk++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
  endtask

  task automatic test_pause_resume();
    exp_t e;
    do_reset();
    press(4'd4); press(4'd5);
    go(4'd10);
    step(2);
    door_closed = 1'b0;
    #1;
    push("door_open_mag_off", mk(COOK, 8'h00, 4'd4, 4'd5, 1'b0, 1'b0));
    e = q.pop_front(); n_chk++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    step();
    push("paused", mk(PAUSE, 8'h00, 4'd4, 4'd5, 1'b0, 1'b0));
    e = q.pop_front(); n_chk++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    step(5);
    push("pause_held", mk(PAUSE, 8'h00, 4'd4, 4'd5, 1'b0, 1'b0));
    e = q.pop_front(); n_chk++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    door_closed = 1'b1;
    go(4'd10);
    push("resumed", mk(COOK, 8'h00, 4'd4, 4'd5, 1'b1, 1'b0));
    e = q.pop_front(); n_chk++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    step(TICK);
    push("resume_tick", mk(COOK, 8'h00, 4'd4, 4'd4, 1'b1, 1'b0));
    e = q.pop_front(); n_chk++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    clr();
  endtask

  task automatic test_duty();
    exp_t e;
    int   t;
    do_reset();
    press(4'd2); press(4'd0);
    go(4'd3);
    for (int k = 0; k < 12; k++) begin
      t = 20 - k;
      push($sformatf("duty3_s%0d", k),
           mk(COOK, 8'h00, 4'(t / 10), 4'(t % 10), (k % 10) < 3, 1'b0));
      e = q.pop_front(); n_chk++;
      if (obs !== e.v) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
      step(TICK);
    end
    clear = 1'b1; start = 1'b1;
    step();
    clear = 1'b0; start = 1'b0;
    push("clear_beats_start", mk(IDLE, 8'h00, 4'd0, 4'd0, 1'b0, 1'b0));
    e = q.pop_front(); n_chk++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    press(4'd2); press(4'd0);
    go(4'd0);
    for (int k = 0; k < 11; k++) begin
      t = 20 - k;
      push($sformatf("duty0_s%0d", k), mk(COOK, 8'h00, 4'(t / 10), 4'(t % 10), 1'b1, 1'b0));
      e = q.pop_front(); n_chk++;
      if (obs !== e.v) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
      step(TICK);
    end
    clr();
  endtask

  task automatic test_borrow();
    exp_t e;
    do_reset();
    press(4'd1); press(4'd0); press(4'd0);
    go(4'd10);
    step(TICK);
    push("borrow_100", mk(COOK, 8'h00, 4'd5, 4'd9, 1'b1, 1'b0));
    e = q.pop_front(); n_chk++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    clr();
    press(4'd9); press(4'd0);
    push("entry_90", mk(SET, 8'h00, 4'd9, 4'd0, 1'b0, 1'b0));
    e = q.pop_front(); n_chk++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    go(4'd10);
    step(TICK);
    push("borrow_90", mk(COOK, 8'h00, 4'd8, 4'd9, 1'b1, 1'b0));
    e = q.pop_front(); n_chk++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    clr();
  endtask

  task automatic test_bad_key();
    exp_t e;
    do_reset();
    press(4'd11);
    push("bad_key_idle", mk(IDLE, 8'h00, 4'd0, 4'd0, 1'b0, 1'b0));
    e = q.pop_front(); n_chk++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    press(4'd5); press(4'd11); press(4'd15);
    push("bad_key_set", mk(SET, 8'h00, 4'd0, 4'd5, 1'b0, 1'b0));
    e = q.pop_front(); n_chk++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
  endtask

  task automatic test_min1();
    exp_t e;
    do_reset();
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    push("min1_1234", {4'h0, 2'(SET), 4'h2, 4'h3, 4'h4, 1'b0, 1'b0});
    e = q.pop_front(); n_chk++;
    if (obs1 !== e.v) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs1, e.v); end
    push("min2_1234", mk(SET, 8'h12, 4'd3, 4'd4, 1'b0, 1'b0));
    e = q.pop_front(); n_chk++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    press(4'd5);
    push("min1_top_drop", {4'h0, 2'(SET), 4'h3, 4'h4, 4'h5, 1'b0, 1'b0});
    e = q.pop_front(); n_chk++;
    if (obs1 !== e.v) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs1, e.v); end
    push("min2_top_drop", mk(SET, 8'h23, 4'd4, 4'd5, 1'b0, 1'b0));
    e = q.pop_front(); n_chk++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
  endtask

  task automatic test_reset_mid_cook();
    exp_t e;
    do_reset();
    press(4'd5);
    go(4'd10);
    step(2);
    reset = 1'b1; start = 1'b1; key_valid = 1'b1; key_digit = 4'd7;
    step();
    reset = 1'b0; start = 1'b0; key_valid = 1'b0;
    push("reset_mid_cook", mk(IDLE, 8'h00, 4'd0, 4'd0, 1'b0, 1'b0));
    e = q.pop_front(); n_chk++;
    if (obs !== e.v) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_entry();
    test_countdown();
    test_pause_resume();
    test_duty();
    test_borrow();
    test_bad_key();
    test_min1();
    test_reset_mid_cook();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cook_timer_ctrl.md
COOK_TIMER_CTRL -- requirements
Module: cook_timer_ctrl

Interface
REQ-001 Parameter MIN_DIGITS, default 2: number of BCD minute digits (1..4).
REQ-002 Parameter TICK_DIV, default 100: clock cycles per one-second tick (>=2).
REQ-003 Parameter POWER_MAX, default 10: number of power levels, which is also the duty window in seconds.
REQ-004 clock  in  1: the single clock; every flop is updated on its rising edge.
REQ-005 reset  in  1: synchronous, active-high reset.
REQ-006 key_valid  in  1: one-cycle keypad strobe.
REQ-007 key_digit  in  4: BCD keypad digit, qualified by key_valid.
REQ-008 start, stop, clear  in  1 each: one-cycle command strobes.
REQ-009 door_closed  in  1: door interlock, level-sensitive.
REQ-010 power_level  in  4: requested power level, sampled on the accepted start.
REQ-011 sec_ones, sec_tens  out  4 each: BCD seconds digits.
REQ-012 mins  out  4*MIN_DIGITS: BCD minute digits, least-significant digit in bits [3:0].
REQ-013 mag_on  out  1: magnetron enable.
REQ-014 state  out  2: current FSM state encoding.
REQ-015 done  out  1: one-cycle pulse when cooking completes.

Function
REQ-016 The FSM SHALL have four states:
- IDLE: time is all-zero.
- SET: time is non-zero and not cooking.
- COOK: counting down.
- PAUSE: counting halted with time retained.
REQ-017 Command priority SHALL be, highest first: clear > stop or door open > start > key.
REQ-018 A key in IDLE or SET with key_digit<=9 SHALL shift the time left by one digit:
- sec_ones takes key_digit.
- Each higher digit takes the digit below it.
- The top minute digit is discarded.
REQ-019 A key with key_digit>9, or a key received in COOK or PAUSE, SHALL be ignored.
REQ-020 Entry SHALL accept sec_tens values 6..9 unchanged; for example, "90" counts down as 90 seconds.
REQ-021 IDLE SHALL move to SET when the shifted time is non-zero; shifting in zeros from IDLE keeps IDLE.
REQ-022 In SET, start with door_closed=1 SHALL do three things:
- Enter COOK.
- Latch power_level; values 0 and >POWER_MAX are stored as POWER_MAX.
- Clear the prescaler and the duty-window counter.
REQ-023 In SET, start with door_closed=0 SHALL be ignored.
REQ-024 In SET or PAUSE, stop or clear SHALL zero all digits and enter IDLE.
REQ-025 In COOK, stop or door_closed=0 SHALL enter PAUSE with all digits held.
REQ-026 In COOK, clear SHALL zero all digits and enter IDLE.
REQ-027 In PAUSE, start with door_closed=1 SHALL re-enter COOK, clearing the prescaler and the window counter and keeping the latched level.
REQ-028 In COOK, the prescaler SHALL count 0..TICK_DIV-1, and each wrap is one tick.
REQ-029 The first decrement SHALL occur TICK_DIV cycles after the start edge.
REQ-030 On each tick the time SHALL decrement with borrow:
- If sec_ones>0, decrement sec_ones.
- Otherwise, if sec_tens>0, decrement sec_tens and set sec_ones to 9.
- Otherwise, borrow from the lowest non-zero minute digit, with lower minute digits becoming 9, and set seconds to 59.
REQ-031 A tick that takes the time to all-zero SHALL, on the same edge:
- Enter IDLE.
- Assert done for exactly one cycle.
REQ-032 The duty-window counter SHALL count seconds 0..POWER_MAX-1 on each tick and then wrap.
REQ-033 mag_on SHALL equal (state==COOK) AND door_closed AND (window count < latched level).
REQ-034 mag_on SHALL fall combinationally when the door opens.
REQ-035 Timer digits SHALL never go below zero or wrap.
REQ-036 Minute digits SHALL never exceed 9.

Reset
REQ-037 While reset=1 at a clock edge, the block SHALL set:
- All digits 0 and state IDLE.
- mag_on 0 and done 0.
- Prescaler 0 and window counter 0.
- Latched level POWER_MAX.
REQ-038 Reset SHALL override all inputs in the same cycle, including reset asserted mid-COOK.

Structure
REQ-039 A package cook_timer_pkg SHALL hold:
- The state enum (IDLE=0, SET=1, COOK=2, PAUSE=3).
- The BCD constants ZERO=0 and NINE=9 and the seconds-tens reload value 5.
REQ-040 One sub-module, bcd_digit_cell, SHALL be instantiated per digit.
REQ-041 Each bcd_digit_cell SHALL provide load (shift-in), decrement with borrow-in/borrow-out, and zero-detect.

Verification (TICK_DIV=4 for the bench)
REQ-042 Reset, then keys 1,3,0 -> mins=0x01, sec_tens=3, sec_ones=0, state=SET.
REQ-043 Time 0:03, level 10, door closed, start -> decrements at +4, +8 and +12 cycles; at +12 done=1 for one cycle, state=IDLE, and mag_on falls on the same edge.
REQ-044 During COOK at 0:45, door opens -> mag_on 0 immediately, then PAUSE with digits 0:45 held; after the door closes, start -> COOK resumes from 0:45.
REQ-045 Time 0:20, level 3 -> mag_on high for 3 ticks and low for 7 ticks, repeating; start with power_level=0 -> mag_on continuously high.
REQ-046 Borrow cases: 1:00 -> 0:59 after one tick; entry "90" -> 89 after one tick.
REQ-047 Key 11 is ignored; with MIN_DIGITS=1, keys 1,2,3,4 -> 2:34; simultaneous clear and start in COOK -> IDLE with all digits zero.
